// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-Lite round-robin arbiter.
// Grant counters exist only when AXIL_ARB_STATS_EN is defined.
package axil_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [ADDR_W-1:0] awaddr;
        logic [2:0]        awprot;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              wvalid;
        logic              bready;
        logic [ADDR_W-1:0] araddr;
        logic [2:0]        arprot;
        logic              arvalid;
        logic              rready;
    } axil_req_t;

    typedef struct packed {
        logic              awready;
        logic              wready;
        logic [1:0]        bresp;
        logic              bvalid;
        logic              arready;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rvalid;
    } axil_rsp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    // Index width for n masters; a single master still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_rr_pick.sv
// Cyclic first-set picker: lowest request index at or after ptr_i wins.
// Purely combinational; used once per direction by the arbiter.
module axil_rr_pick
    import axil_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    // Walk the requests starting from the pointer, wrapping once
    always_comb begin
        int          j;
        logic [IW-1:0] jj;
        logic        hit;
        gnt_o = '0;
        idx_o = '0;
        hit   = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (!hit && req_i[jj]) begin
                hit       = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end

endmodule

// File: rtl/axil_rr_arbiter.sv
// N-to-1 AXI4-Lite arbiter, independent round-robin write and read paths.
// Define AXIL_ARB_STATS_EN to add saturating per-master completion counters.
module axil_rr_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_MST = 2
`ifdef AXIL_ARB_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic      aclk,
    input  logic      areset,
    input  axil_req_t s_req [NUM_MST],
    output axil_rsp_t s_rsp [NUM_MST],
    output axil_req_t m_req,
    input  axil_rsp_t m_rsp
`ifdef AXIL_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] wr_grant_cnt [NUM_MST],
    output logic [CNT_W-1:0] rd_grant_cnt [NUM_MST]
`endif
);

    localparam int IW = idx_w(NUM_MST);

    wr_state_e     wr_state_q;
    logic [IW-1:0] wgnt_q;
    logic [IW-1:0] wr_ptr_q;
    logic          aw_done_q;
    logic          w_done_q;
    logic          aw_done_d;
    logic          w_done_d;

    rd_state_e     rd_state_q;
    logic [IW-1:0] rgnt_q;
    logic [IW-1:0] rd_ptr_q;

    logic [NUM_MST-1:0] aw_req;
    logic [NUM_MST-1:0] ar_req;
    logic [NUM_MST-1:0] wr_gnt;
    logic [NUM_MST-1:0] rd_gnt;
    logic [IW-1:0]      wr_idx;
    logic [IW-1:0]      rd_idx;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    // Pointer advance past the master just served, wrapping at NUM_MST
    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        if (int'(p) >= NUM_MST - 1) begin
            return '0;
        end
        return p + IW'(1);
    endfunction

    // Gather the address-valid request vectors for both directions
    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            aw_req[i] = s_req[i].awvalid;
            ar_req[i] = s_req[i].arvalid;
        end
    end

    axil_rr_pick #(
        .N  (NUM_MST),
        .IW (IW)
    ) u_wr_pick (
        .req_i (aw_req),
        .ptr_i (wr_ptr_q),
        .gnt_o (wr_gnt),
        .idx_o (wr_idx)
    );

    axil_rr_pick #(
        .N  (NUM_MST),
        .IW (IW)
    ) u_rd_pick (
        .req_i (ar_req),
        .ptr_i (rd_ptr_q),
        .gnt_o (rd_gnt),
        .idx_o (rd_idx)
    );

    // Handshakes as seen on the shared slave side
    always_comb begin
        aw_hs     = m_req.awvalid & m_rsp.awready;
        w_hs      = m_req.wvalid & m_rsp.wready;
        b_hs      = m_rsp.bvalid & m_req.bready;
        ar_hs     = m_req.arvalid & m_rsp.arready;
        r_hs      = m_rsp.rvalid & m_req.rready;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
    end

    // Route the granted master to the slave; everyone else sees zeros
    always_comb begin
        m_req = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            s_rsp[i] = '0;
        end

        unique case (wr_state_q)
            W_ADDR: begin
                if (!aw_done_q) begin
                    m_req.awvalid = s_req[wgnt_q].awvalid;
                    if (s_req[wgnt_q].awvalid) begin
                        m_req.awaddr = s_req[wgnt_q].awaddr;
                        m_req.awprot = s_req[wgnt_q].awprot;
                    end
                    s_rsp[wgnt_q].awready = m_rsp.awready;
                end
                if (!w_done_q) begin
                    m_req.wvalid = s_req[wgnt_q].wvalid;
                    if (s_req[wgnt_q].wvalid) begin
                        m_req.wdata = s_req[wgnt_q].wdata;
                        m_req.wstrb = s_req[wgnt_q].wstrb;
                    end
                    s_rsp[wgnt_q].wready = m_rsp.wready;
                end
            end
            W_RESP: begin
                m_req.bready         = s_req[wgnt_q].bready;
                s_rsp[wgnt_q].bvalid = m_rsp.bvalid;
                s_rsp[wgnt_q].bresp  = m_rsp.bvalid ? m_rsp.bresp
                                                    : RESP_OKAY;
            end
            default: begin
            end
        endcase

        unique case (rd_state_q)
            R_ADDR: begin
                m_req.arvalid = s_req[rgnt_q].arvalid;
                if (s_req[rgnt_q].arvalid) begin
                    m_req.araddr = s_req[rgnt_q].araddr;
                    m_req.arprot = s_req[rgnt_q].arprot;
                end
                s_rsp[rgnt_q].arready = m_rsp.arready;
            end
            R_DATA: begin
                m_req.rready         = s_req[rgnt_q].rready;
                s_rsp[rgnt_q].rvalid = m_rsp.rvalid;
                if (m_rsp.rvalid) begin
                    s_rsp[rgnt_q].rdata = m_rsp.rdata;
                    s_rsp[rgnt_q].rresp = m_rsp.rresp;
                end
            end
            default: begin
            end
        endcase
    end

    // Write FSM: grant, collect AW and W in any order, wait for B
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q <= W_IDLE;
            wgnt_q     <= '0;
            wr_ptr_q   <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            unique case (wr_state_q)
                W_IDLE: begin
                    if (|wr_gnt) begin
                        wgnt_q     <= wr_idx;
                        wr_state_q <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        wr_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        wr_ptr_q   <= ptr_inc(wgnt_q);
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Read FSM: grant, forward AR, wait for R
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state_q <= R_IDLE;
            rgnt_q     <= '0;
            rd_ptr_q   <= '0;
        end else begin
            unique case (rd_state_q)
                R_IDLE: begin
                    if (|rd_gnt) begin
                        rgnt_q     <= rd_idx;
                        rd_state_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (ar_hs) begin
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        rd_ptr_q   <= ptr_inc(rgnt_q);
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

`ifdef AXIL_ARB_STATS_EN
    logic [CNT_W-1:0] wr_cnt_q [NUM_MST];
    logic [CNT_W-1:0] rd_cnt_q [NUM_MST];

    // Count completed responses per master, holding at all-ones
    always_ff @(posedge aclk) begin
        for (int i = 0; i < NUM_MST; i++) begin
            if (areset) begin
                wr_cnt_q[i] <= '0;
                rd_cnt_q[i] <= '0;
            end else begin
                if (b_hs && wgnt_q == IW'(i)
                    && wr_cnt_q[i] != {CNT_W{1'b1}}) begin
                    wr_cnt_q[i] <= wr_cnt_q[i] + CNT_W'(1);
                end
                if (r_hs && rgnt_q == IW'(i)
                    && rd_cnt_q[i] != {CNT_W{1'b1}}) begin
                    rd_cnt_q[i] <= rd_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign wr_grant_cnt = wr_cnt_q;
    assign rd_grant_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Randomized bench: N masters and one slave agent around the arbiter,
// checked every cycle against a transaction-level arbitration model.
module tb_axil_rr_arbiter;
    import axil_arb_pkg::*;

    localparam int N     = 3;
    localparam int CNT_W = 16;
    localparam int NCYC  = 4000;

    logic      aclk = 1'b0;
    logic      areset;
    axil_req_t s_req [N];
    axil_rsp_t s_rsp [N];
    axil_req_t m_req;
    axil_rsp_t m_rsp;
`ifdef AXIL_ARB_STATS_EN
    logic [CNT_W-1:0] wr_grant_cnt [N];
    logic [CNT_W-1:0] rd_grant_cnt [N];
`endif

    always #5 aclk = ~aclk;

    axil_rr_arbiter #(
        .NUM_MST (N)
`ifdef AXIL_ARB_STATS_EN
        ,
        .CNT_W   (CNT_W)
`endif
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .s_req  (s_req),
        .s_rsp  (s_rsp),
        .m_req  (m_req),
        .m_rsp  (m_rsp)
`ifdef AXIL_ARB_STATS_EN
        ,
        .wr_grant_cnt (wr_grant_cnt),
        .rd_grant_cnt (rd_grant_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h",
                     tag, $time, obs, exp);
        end
    endtask

    // Reference model: who owns each direction and what has been seen
    bit wb, wph, wad, wwd;
    int wo, wptr;
    bit rb, rph;
    int ro, rptr;
    int exp_wcnt [N];
    int exp_rcnt [N];

    // Master agents
    bit          w_act [N], aw_v [N], w_v [N], aw_sent [N], w_sent [N];
    int          aw_dly [N], w_dly [N], w_age [N];
    logic [31:0] w_addr [N], w_data [N];
    logic [3:0]  w_strb [N];
    bit          b_rdy [N];
    bit          r_act [N], ar_v [N], r_rdy [N];
    int          ar_dly [N], r_age [N];
    logic [31:0] r_addr [N];
    int          n_wdone [N], n_rdone [N];

    // Slave agent
    int          sl_aw_cnt, sl_w_cnt, sl_ar_cnt;
    logic [31:0] sl_awaddr, sl_wdata, sl_araddr, sl_rdata;
    logic [3:0]  sl_wstrb;
    bit          sl_awr, sl_wr, sl_arr, sl_bv, sl_rv;
    logic [1:0]  sl_bresp, sl_rresp;

    bit force_all, pend_force, did_mid, post_rst;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_req[i].awvalid = aw_v[i];
            s_req[i].awaddr  = aw_v[i] ? w_addr[i] : $urandom;
            s_req[i].awprot  = aw_v[i] ? 3'(i) : 3'($urandom);
            s_req[i].wvalid  = w_v[i];
            s_req[i].wdata   = w_v[i] ? w_data[i] : $urandom;
            s_req[i].wstrb   = w_v[i] ? w_strb[i] : 4'($urandom);
            s_req[i].bready  = b_rdy[i];
            s_req[i].arvalid = ar_v[i];
            s_req[i].araddr  = ar_v[i] ? r_addr[i] : $urandom;
            s_req[i].arprot  = ar_v[i] ? 3'(i) : 3'($urandom);
            s_req[i].rready  = r_rdy[i];
        end
        m_rsp.awready = sl_awr;
        m_rsp.wready  = sl_wr;
        m_rsp.bvalid  = sl_bv;
        m_rsp.bresp   = sl_bv ? sl_bresp : 2'($urandom);
        m_rsp.arready = sl_arr;
        m_rsp.rvalid  = sl_rv;
        m_rsp.rdata   = sl_rv ? sl_rdata : $urandom;
        m_rsp.rresp   = sl_rv ? sl_rresp : 2'($urandom);
    endtask

    task automatic agents_step();
        if (areset) return;
        for (int i = 0; i < N; i++) begin
            if (!w_act[i] && (force_all || $urandom_range(0, 3) == 0)) begin
                w_act[i]   = 1'b1;
                aw_sent[i] = 1'b0;
                w_sent[i]  = 1'b0;
                w_age[i]   = 0;
                w_addr[i]  = $urandom & 32'hFFFF_FFFC;
                w_data[i]  = $urandom;
                w_strb[i]  = 4'($urandom);
                aw_dly[i]  = force_all ? 0 : $urandom_range(0, 4);
                w_dly[i]   = $urandom_range(0, 4);
            end
            if (w_act[i]) w_age[i]++;
            if (w_act[i] && !aw_sent[i] && !aw_v[i]) begin
                if (aw_dly[i] == 0) aw_v[i] = 1'b1;
                else aw_dly[i]--;
            end
            if (w_act[i] && !w_sent[i] && !w_v[i]) begin
                if (w_dly[i] == 0) w_v[i] = 1'b1;
                else w_dly[i]--;
            end
            b_rdy[i] = 1'($urandom_range(0, 1));
            if (!r_act[i] && $urandom_range(0, 3) == 0) begin
                r_act[i]  = 1'b1;
                r_age[i]  = 0;
                r_addr[i] = $urandom & 32'hFFFF_FFFC;
                ar_dly[i] = $urandom_range(0, 3);
            end
            if (r_act[i]) r_age[i]++;
            if (r_act[i] && !ar_v[i] && ar_dly[i] >= 0) begin
                if (ar_dly[i] == 0) begin
                    ar_v[i]   = 1'b1;
                    ar_dly[i] = -1;
                end else ar_dly[i]--;
            end
            r_rdy[i] = 1'($urandom_range(0, 1));
        end
        force_all = 1'b0;
        sl_awr = 1'($urandom_range(0, 1));
        sl_wr  = 1'($urandom_range(0, 1));
        sl_arr = 1'($urandom_range(0, 1));
        if (!sl_bv && sl_aw_cnt > 0 && sl_w_cnt > 0
            && $urandom_range(0, 2) == 0) begin
            sl_bv    = 1'b1;
            sl_bresp = 2'($urandom);
        end
        if (!sl_rv && sl_ar_cnt > 0 && $urandom_range(0, 2) == 0) begin
            sl_rv    = 1'b1;
            sl_rdata = $urandom;
            sl_rresp = 2'($urandom);
        end
    endtask

    task automatic sample();
        logic e_awv, e_wv, e_arv;
        logic e_awr, e_wr, e_bv, e_arr, e_rv;
        bit   m_aw_hs, m_w_hs, m_b_hs, m_ar_hs, m_r_hs;
        if (areset) begin
            wb = 0; wph = 0; wad = 0; wwd = 0; wo = 0; wptr = 0;
            rb = 0; rph = 0; ro = 0; rptr = 0;
            for (int i = 0; i < N; i++) begin
                exp_wcnt[i] = 0; exp_rcnt[i] = 0;
                w_act[i] = 0; aw_v[i] = 0; w_v[i] = 0;
                r_act[i] = 0; ar_v[i] = 0; ar_dly[i] = 0;
            end
            sl_aw_cnt = 0; sl_w_cnt = 0; sl_ar_cnt = 0;
            sl_bv = 0; sl_rv = 0;
            post_rst = 1'b1;
            return;
        end
        if (post_rst) begin
            check("rst_m_vld", 64'({m_req.awvalid, m_req.wvalid,
                  m_req.bready, m_req.arvalid, m_req.rready}), 64'(0));
            for (int i = 0; i < N; i++)
                check("rst_s_vld", 64'({s_rsp[i].awready, s_rsp[i].wready,
                      s_rsp[i].bvalid, s_rsp[i].arready, s_rsp[i].rvalid}),
                      64'(0));
            post_rst = 1'b0;
        end

        e_awv = wb && !wph && !wad && s_req[wo].awvalid;
        e_wv  = wb && !wph && !wwd && s_req[wo].wvalid;
        e_arv = rb && !rph && s_req[ro].arvalid;
        check("m_aw", 64'({m_req.awvalid, m_req.awaddr, m_req.awprot}),
              e_awv ? 64'({1'b1, s_req[wo].awaddr, s_req[wo].awprot})
                    : 64'(0));
        check("m_w", 64'({m_req.wvalid, m_req.wdata, m_req.wstrb}),
              e_wv ? 64'({1'b1, s_req[wo].wdata, s_req[wo].wstrb})
                   : 64'(0));
        check("m_bready", 64'(m_req.bready),
              64'(wb && wph && s_req[wo].bready));
        check("m_ar", 64'({m_req.arvalid, m_req.araddr, m_req.arprot}),
              e_arv ? 64'({1'b1, s_req[ro].araddr, s_req[ro].arprot})
                    : 64'(0));
        check("m_rready", 64'(m_req.rready),
              64'(rb && rph && s_req[ro].rready));

        for (int i = 0; i < N; i++) begin
            e_awr = (wb && wo == i && !wph && !wad) ? m_rsp.awready : 1'b0;
            e_wr  = (wb && wo == i && !wph && !wwd) ? m_rsp.wready : 1'b0;
            e_bv  = (wb && wo == i && wph) ? m_rsp.bvalid : 1'b0;
            e_arr = (rb && ro == i && !rph) ? m_rsp.arready : 1'b0;
            e_rv  = (rb && ro == i && rph) ? m_rsp.rvalid : 1'b0;
            check("s_route", 64'({s_rsp[i].awready, s_rsp[i].wready,
                  s_rsp[i].bvalid, s_rsp[i].arready, s_rsp[i].rvalid}),
                  64'({e_awr, e_wr, e_bv, e_arr, e_rv}));
            if (s_rsp[i].bvalid && s_req[i].bready) begin
                check("b_resp", 64'(s_rsp[i].bresp), 64'(sl_bresp));
                check("b_addr", 64'(sl_awaddr), 64'(w_addr[i]));
                check("b_data", 64'({sl_wdata, sl_wstrb}),
                      64'({w_data[i], w_strb[i]}));
                check("b_once", {32'(sl_aw_cnt), 32'(sl_w_cnt)},
                      {32'd1, 32'd1});
                check("w_age", 64'(w_age[i] <= 400), 64'(1));
                n_wdone[i]++;
            end
            if (s_rsp[i].rvalid && s_req[i].rready) begin
                check("r_data", 64'({s_rsp[i].rdata, s_rsp[i].rresp}),
                      64'({sl_rdata, sl_rresp}));
                check("r_addr", 64'(sl_araddr), 64'(r_addr[i]));
                check("r_once", 64'(sl_ar_cnt), 64'(1));
                check("r_age", 64'(r_age[i] <= 400), 64'(1));
                n_rdone[i]++;
            end
`ifdef AXIL_ARB_STATS_EN
            check("wr_cnt", 64'(wr_grant_cnt[i]), 64'(exp_wcnt[i]));
            check("rd_cnt", 64'(rd_grant_cnt[i]), 64'(exp_rcnt[i]));
`endif
        end

        m_aw_hs = m_req.awvalid && m_rsp.awready;
        m_w_hs  = m_req.wvalid && m_rsp.wready;
        m_b_hs  = m_rsp.bvalid && m_req.bready;
        m_ar_hs = m_req.arvalid && m_rsp.arready;
        m_r_hs  = m_rsp.rvalid && m_req.rready;

        if (!wb) begin
            for (int k = 0; k < N && !wb; k++)
                if (s_req[(wptr + k) % N].awvalid) begin
                    wb = 1; wo = (wptr + k) % N;
                    wad = 0; wwd = 0; wph = 0;
                end
        end else if (!wph) begin
            if (m_aw_hs) wad = 1;
            if (m_w_hs) wwd = 1;
            if (wad && wwd) wph = 1;
        end else if (m_b_hs) begin
            wb = 0;
            wptr = (wo + 1) % N;
            if (exp_wcnt[wo] < (1 << CNT_W) - 1) exp_wcnt[wo]++;
        end
        if (!rb) begin
            for (int k = 0; k < N && !rb; k++)
                if (s_req[(rptr + k) % N].arvalid) begin
                    rb = 1; ro = (rptr + k) % N; rph = 0;
                end
        end else if (!rph) begin
            if (m_ar_hs) rph = 1;
        end else if (m_r_hs) begin
            rb = 0;
            rptr = (ro + 1) % N;
            if (exp_rcnt[ro] < (1 << CNT_W) - 1) exp_rcnt[ro]++;
        end

        for (int i = 0; i < N; i++) begin
            if (s_req[i].awvalid && s_rsp[i].awready) begin
                aw_v[i] = 0; aw_sent[i] = 1;
            end
            if (s_req[i].wvalid && s_rsp[i].wready) begin
                w_v[i] = 0; w_sent[i] = 1;
            end
            if (s_rsp[i].bvalid && s_req[i].bready) w_act[i] = 0;
            if (s_req[i].arvalid && s_rsp[i].arready) ar_v[i] = 0;
            if (s_rsp[i].rvalid && s_req[i].rready) begin
                r_act[i] = 0; ar_dly[i] = 0;
            end
        end
        if (m_aw_hs) begin sl_awaddr = m_req.awaddr; sl_aw_cnt++; end
        if (m_w_hs) begin
            sl_wdata = m_req.wdata; sl_wstrb = m_req.wstrb; sl_w_cnt++;
        end
        if (m_b_hs) begin sl_bv = 0; sl_aw_cnt = 0; sl_w_cnt = 0; end
        if (m_ar_hs) begin sl_araddr = m_req.araddr; sl_ar_cnt++; end
        if (m_r_hs) begin sl_rv = 0; sl_ar_cnt = 0; end
    endtask

    initial begin
        areset = 1'b1;
        drive();
        for (int c = 0; c < NCYC; c++) begin
            @(posedge aclk);
            #1;
            if (c < 3) begin
                areset = 1'b1;
            end else if (!did_mid && c > 1500 && wb && wph && sl_bv) begin
                areset     = 1'b1;
                did_mid    = 1'b1;
                pend_force = 1'b1;
            end else begin
                areset     = 1'b0;
                force_all  = pend_force;
                pend_force = 1'b0;
            end
            agents_step();
            drive();
            @(negedge aclk);
            sample();
        end
        for (int i = 0; i < N; i++) begin
            check("wr_progress", 64'(n_wdone[i] > 0), 64'(1));
            check("rd_progress", 64'(n_rdone[i] > 0), 64'(1));
        end
        check("mid_rst_hit", 64'(did_mid), 64'(1));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
